g06_pio_bank: RTL and testbench



---
 rtl/g06_pio_pkg.sv | 19 +
 rtl/g06_pio_bank_if.sv | 14 +
 rtl/g06_debounce.sv | 38 +++
 rtl/g06_pio_bank.sv | 90 +++++++++
 tb/tb_g06_pio_bank.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/g06_pio_pkg.sv
// g06_pio_pkg: register map, ID byte and parameter limits shared by the PIO bank.
package g06_pio_pkg;
   typedef logic [2:0] reg_addr_t;
   localparam reg_addr_t REG_IN   = 3'd0;
   localparam reg_addr_t REG_OUT  = 3'd1;
   localparam reg_addr_t REG_SET  = 3'd2;
   localparam reg_addr_t REG_CLR  = 3'd3;
   localparam reg_addr_t REG_MASK = 3'd4;
   localparam reg_addr_t REG_CAP  = 3'd5;
   localparam reg_addr_t REG_POL  = 3'd6;
   localparam reg_addr_t REG_INFO = 3'd7;
   localparam logic [7:0] INFO_ID = 8'h06;
   localparam int MIN_W   = 1;
   localparam int MAX_W   = 32;
   localparam int MIN_DEB = 2;
   function automatic logic [31:0] info_word(input int in_w, input int out_w);
      return {INFO_ID, 8'd0, 8'(in_w), 8'(out_w)};
   endfunction
endpackage

// File: rtl/g06_pio_bank_if.sv
// g06_pio_bank_if: Avalon-MM slave signals of the PIO bank.
interface g06_pio_bank_if;
   import g06_pio_pkg::*;
   reg_addr_t   avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   modport master (output avs_address, avs_read, avs_write, avs_writedata,
                   input  avs_readdata, avs_readdatavalid);
   modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                   output avs_readdata, avs_readdatavalid);
endinterface

// File: rtl/g06_debounce.sv
// g06_debounce: one input bit, 2-flop synchroniser plus stability counter; pulses on accepted edges.
module g06_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_state,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
   logic          r_s1;
   logic          r_s2;
   logic          r_state;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_take;
   assign w_diff = r_s2 ^ r_state;
   assign w_take = w_diff & (r_cnt == LAST);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_state <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_cnt   <= (w_diff && !w_take) ? r_cnt + 1'b1 : '0;
         r_state <= w_take ? r_s2 : r_state;
      end
   end
   assign o_state = r_state;
   assign o_rise  = w_take & r_s2;
   assign o_fall  = w_take & ~r_s2;
endmodule

// File: rtl/g06_pio_bank.sv
// g06_pio_bank: debounced inputs with edge capture/irq and set/clear outputs on one Avalon-MM slave.
module g06_pio_bank
   import g06_pio_pkg::*;
#(
   parameter int IN_W       = 10,
   parameter int OUT_W      = 32,
   parameter int DEB_CYCLES = 50000,
   parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   g06_pio_bank_if.slave       bus,
   output logic                irq,
   input  logic [IN_W-1:0]     pio_in,
   output logic [OUT_W-1:0]    pio_out
);
   if (IN_W < MIN_W || IN_W > MAX_W || OUT_W < MIN_W || OUT_W > MAX_W || DEB_CYCLES < MIN_DEB) begin : g_bad_param
      $error("g06_pio_bank: parameter out of range");
   end
   logic [IN_W-1:0]  w_in;
   logic [IN_W-1:0]  w_rise;
   logic [IN_W-1:0]  w_fall;
   logic [IN_W-1:0]  w_edge;
   logic [IN_W-1:0]  w_w1c;
   logic [IN_W-1:0]  w_win;
   logic [OUT_W-1:0] w_wout;
   logic [OUT_W-1:0] w_out_nxt;
   logic [31:0]      w_rdata;
   logic [IN_W-1:0]  r_mask;
   logic [IN_W-1:0]  r_cap;
   logic [IN_W-1:0]  r_pol;
   logic [OUT_W-1:0] r_out;
   logic [31:0]      r_rdata;
   logic             r_rvalid;
   logic             r_irq;
   for (genvar b = 0; b < IN_W; b++) begin : g_deb
      g06_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk     (clk_clk),
         .rst     (reset_reset),
         .i_raw   (pio_in[b]),
         .o_state (w_in[b]),
         .o_rise  (w_rise[b]),
         .o_fall  (w_fall[b])
      );
   end
   assign w_win  = bus.avs_writedata[IN_W-1:0];
   assign w_wout = bus.avs_writedata[OUT_W-1:0];
   assign w_edge = (w_rise & ~r_pol) | (w_fall & r_pol);
   assign w_w1c  = (bus.avs_write && bus.avs_address == REG_CAP) ? w_win : '0;
   assign w_out_nxt = !bus.avs_write              ? r_out :
                      bus.avs_address == REG_OUT ? w_wout :
                      bus.avs_address == REG_SET ? r_out | w_wout :
                      bus.avs_address == REG_CLR ? r_out & ~w_wout : r_out;
   always_comb begin
      w_rdata = '0;
      case (bus.avs_address)
         REG_IN:   w_rdata = 32'(w_in);
         REG_OUT:  w_rdata = 32'(r_out);
         REG_MASK: w_rdata = 32'(r_mask);
         REG_CAP:  w_rdata = 32'(r_cap);
         REG_POL:  w_rdata = 32'(r_pol);
         REG_INFO: w_rdata = info_word(IN_W, OUT_W);
         default:  w_rdata = '0;
      endcase
   end
   // a new edge is OR-ed in after the W1C so that set wins on a collision
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_out    <= OUT_RESET;
         r_mask   <= '0;
         r_pol    <= '0;
         r_cap    <= '0;
         r_irq    <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_out    <= w_out_nxt;
         r_mask   <= (bus.avs_write && bus.avs_address == REG_MASK) ? w_win : r_mask;
         r_pol    <= (bus.avs_write && bus.avs_address == REG_POL) ? w_win : r_pol;
         r_cap    <= (r_cap & ~w_w1c) | w_edge;
         r_irq    <= |(r_cap & r_mask);
         r_rvalid <= bus.avs_read;
         r_rdata  <= bus.avs_read ? w_rdata : r_rdata;
      end
   end
   assign bus.avs_readdata      = r_rdata;
   assign bus.avs_readdatavalid = r_rvalid;
   assign irq                   = r_irq;
   assign pio_out               = r_out;
endmodule

// File: tb/tb_g06_pio_bank.sv
// tb_g06_pio_bank: directed plan plus random traffic against a window-based reference model.
module tb_g06_pio_bank;
   import g06_pio_pkg::*;
   localparam int DEB = 4;
   localparam int IW  = 10;
   localparam int OW  = 32;
   logic           clk_clk = 1'b0;
   logic           reset_reset = 1'b1;
   logic           irq;
   logic [IW-1:0]  pio_in = '0;
   logic [OW-1:0]  pio_out;
   int             n_chk = 0;
   int             n_fail = 0;
   logic [IW-1:0]  raw [0:DEB+1];
   logic [IW-1:0]  m_in = '0, m_mask = '0, m_pol = '0, m_cap = '0;
   logic [OW-1:0]  m_out = '0;
   logic [31:0]    m_rdata = '0;
   logic           m_rvalid = 1'b0, m_irq = 1'b0;
   logic [31:0]    rd_val;
   g06_pio_bank_if bus();
   g06_pio_bank #(.IN_W(IW), .OUT_W(OW), .DEB_CYCLES(DEB), .OUT_RESET(32'h0)) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .bus         (bus),
      .irq         (irq),
      .pio_in      (pio_in),
      .pio_out     (pio_out)
   );
   always #5 clk_clk = ~clk_clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return 32'(m_in);
         3'd1: return 32'(m_out);
         3'd4: return 32'(m_mask);
         3'd5: return 32'(m_cap);
         3'd6: return 32'(m_pol);
         3'd7: return {8'h06, 8'h00, 8'(IW), 8'(OW)};
         default: return 32'h0;
      endcase
   endfunction
   // an input is accepted once the last DEB synchronised samples all disagree with it
   task automatic model_step();
      logic [IW-1:0] flip, nin, edg, w1c, wn;
      logic [31:0]   wd;
      if (reset_reset) begin
         for (int i = 0; i < DEB + 2; i++) raw[i] = '0;
         m_in = '0; m_mask = '0; m_pol = '0; m_cap = '0; m_out = '0;
         m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
      end else begin
         for (int i = DEB + 1; i > 0; i--) raw[i] = raw[i-1];
         raw[0] = pio_in;
         flip = '1;
         for (int i = 2; i < DEB + 2; i++) flip &= raw[i] ^ m_in;
         nin = m_in ^ flip;
         edg = (nin & ~m_in & ~m_pol) | (~nin & m_in & m_pol);
         m_irq = |(m_cap & m_mask);
         if (bus.avs_read) m_rdata = model_read(bus.avs_address);
         m_rvalid = bus.avs_read;
         wd = bus.avs_writedata;
         wn = wd[IW-1:0];
         w1c = '0;
         if (bus.avs_write) begin
            case (bus.avs_address)
               3'd1: m_out = wd;
               3'd2: m_out = m_out | wd;
               3'd3: m_out = m_out & ~wd;
               3'd4: m_mask = wn;
               3'd5: w1c = wn;
               3'd6: m_pol = wn;
               default: ;
            endcase
         end
         m_cap = (m_cap & ~w1c) | edg;
         m_in = nin;
      end
   endtask
   task automatic tick();
      @(posedge clk_clk);
      model_step();
      @(negedge clk_clk);
      chk("pio_out", 32'(pio_out), 32'(m_out));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("rvalid", 32'(bus.avs_readdatavalid), 32'(m_rvalid));
      chk("rdata", bus.avs_readdata, m_rdata);
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
      tick();
      bus.avs_write = 1'b0;
   endtask
   task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
      bus.avs_address = a; bus.avs_read = 1'b1;
      tick();
      bus.avs_read = 1'b0;
      rd_val = bus.avs_readdata;
      chk(tag, rd_val, exp);
   endtask
   initial begin
      bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
      ticks(3);
      reset_reset = 1'b0;
      chk("rst_pio_out", 32'(pio_out), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_rdata", bus.avs_readdata, 32'h0);
      rd_chk(3'd7, 32'h0600_0A20, "info");
      rd_chk(3'd1, 32'h0, "out_rst");
      wr(3'd1, 32'h0000_00F0); chk("out_wr", 32'(pio_out), 32'h0000_00F0);
      wr(3'd2, 32'h0000_000F); chk("out_set", 32'(pio_out), 32'h0000_00FF);
      wr(3'd3, 32'h0000_0030); chk("out_clr", 32'(pio_out), 32'h0000_00CF);
      rd_chk(3'd1, 32'h0000_00CF, "out_rd");
      pio_in[3] = 1'b1; ticks(3); pio_in[3] = 1'b0; ticks(8);
      rd_chk(3'd0, 32'h0, "glitch_in");
      rd_chk(3'd5, 32'h0, "glitch_cap");
      pio_in[3] = 1'b1; ticks(5);
      rd_chk(3'd0, 32'h0, "in_before6");
      rd_chk(3'd0, 32'h008, "in_at6");
      wr(3'd5, 32'h008);
      rd_chk(3'd5, 32'h0, "cap_w1c");
      pio_in[3] = 1'b0; ticks(8);
      rd_chk(3'd5, 32'h0, "fall_nocap");
      wr(3'd4, 32'h008);
      pio_in[3] = 1'b1; ticks(6);
      chk("irq_pre", 32'(irq), 32'h0);
      rd_chk(3'd5, 32'h008, "cap_rise");
      chk("irq_set", 32'(irq), 32'h1);
      wr(3'd5, 32'h008);
      chk("irq_hold", 32'(irq), 32'h1);
      tick();
      chk("irq_fall", 32'(irq), 32'h0);
      wr(3'd6, 32'h001);
      pio_in[0] = 1'b1; ticks(8);
      rd_chk(3'd5, 32'h0, "pol_rise");
      pio_in[0] = 1'b0; ticks(8);
      rd_chk(3'd5, 32'h001, "pol_fall");
      wr(3'd4, 32'h009);
      chk("unmask_pre", 32'(irq), 32'h0);
      tick();
      chk("unmask_irq", 32'(irq), 32'h1);
      wr(3'd5, 32'h001);
      rd_chk(3'd5, 32'h0, "pol_clr");
      pio_in[0] = 1'b1; ticks(8);
      pio_in[0] = 1'b0; ticks(5);
      wr(3'd5, 32'h001);
      rd_chk(3'd5, 32'h001, "set_wins");
      pio_in = 10'h020; ticks(3);
      bus.avs_address = 3'd4; bus.avs_read = 1'b1; reset_reset = 1'b1;
      tick();
      bus.avs_read = 1'b0;
      chk("rst_rvalid", 32'(bus.avs_readdatavalid), 32'h0);
      tick();
      reset_reset = 1'b0;
      chk("rst2_pio_out", 32'(pio_out), 32'h0);
      chk("rst2_irq", 32'(irq), 32'h0);
      rd_chk(3'd5, 32'h0, "rst_cap");
      rd_chk(3'd4, 32'h0, "rst_mask");
      rd_chk(3'd6, 32'h0, "rst_pol");
      rd_chk(3'd1, 32'h0, "rst_out");
      tick();
      rd_chk(3'd0, 32'h0, "rst_in_before6");
      rd_chk(3'd0, 32'h020, "rst_in_at6");
      for (int i = 0; i < 800; i++) begin
         logic [1:0] op;
         if ($urandom_range(0, 3) == 0) begin
            int k;
            k = $urandom_range(0, IW - 1);
            pio_in[k] = ~pio_in[k];
         end
         op = 2'($urandom_range(0, 3));
         bus.avs_read = op[0];
         bus.avs_write = op[1];
         bus.avs_address = 3'($urandom_range(0, 7));
         bus.avs_writedata = $urandom;
         reset_reset = (i == 400);
         tick();
      end
      bus.avs_read = 1'b0; bus.avs_write = 1'b0; reset_reset = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
